vga_scan_engine: RTL and testbench
==================================

# vga_scan_engine

Parametrised successor to the fixed 640x480 VGA timing/display path. Generates sync and blanking from fully configurable timing parameters. Produces incrementally computed framebuffer read addresses for an integer power-of-two upscale of a smaller source image, and aligns sync/blank with registered RGB after a configurable RAM read latency. Sits between the dual-port framebuffer read port and the VGA connector, on the pixel clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 0, active level of hs/vs (0 = active-low)
- SCALE_SHIFT, 2, upscale factor 2^SCALE_SHIFT in both axes (source 160x120 at default)
- ADDR_WIDTH, 15, framebuffer address width
- PIX_WIDTH, 1, framebuffer word width; must be 1 or 3*CH_BITS
- CH_BITS, 1, bits per colour channel
- MEM_LATENCY, 1, framebuffer read latency in clocks (>=1)

Ports:
- clk_25 in 1: pixel clock; the only clock
- reset_n in 1: asynchronous, active-low reset
- rd_data in PIX_WIDTH: framebuffer read data
- pattern_en in 1: test-pattern request; present only with VGA_TEST_PATTERN_EN
- rd_addr out ADDR_WIDTH: framebuffer read address, registered
- rgb out 3*CH_BITS: pixel colour {R,G,B}, registered
- hs out 1: horizontal sync
- vs out 1: vertical sync
- bright out 1: active-video flag aligned with rgb
- frame_start out 1: one-cycle pulse aligned with the first active pixel of each frame at rgb

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt runs 0..H_TOTAL-1; it wraps and advances v_cnt, which runs 0..V_TOTAL-1 and wraps.
- Raw hs is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. Raw vs follows the same rule on v_cnt. Raw bright = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Address generation (no multiplier), SRC_W = H_ACTIVE>>SCALE_SHIFT:
  - line_base is cleared at v_cnt wrap.
  - At the end of each line whose v_cnt[SCALE_SHIFT-1:0] is all ones, line_base += SRC_W.
  - rd_addr reloads to line_base at h_cnt wrap. During active pixels it increments once every 2^SCALE_SHIFT pixels.
  - Equivalent to rd_addr = (v>>S)*SRC_W + (h>>S) for the active pixel (h,v), modulo 2^ADDR_WIDTH. Wrap is silent.
- Pixel mapping, data returning MEM_LATENCY cycles after address:
  - PIX_WIDTH=1: each channel is all ones if the bit is 1, else zero.
  - PIX_WIDTH=3*CH_BITS: rd_data passes straight through.
- Raw hs/vs/bright are delayed D = MEM_LATENCY+1 cycles so they align with registered rgb. rgb is forced to 0 whenever the delayed bright is 0.
- Reset values: counters 0, line_base 0, rd_addr 0, rgb 0, bright 0, frame_start 0, hs = vs = ~SYNC_POL (inactive). The delay line clears to its inactive state.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The scan restarts at (0,0) on the first clock after release.

## Timing
- rd_addr for pixel (h,v) is registered in the cycle h_cnt=h. rgb/bright/hs/vs for that pixel appear D cycles later.
- frame_start is high for exactly one cycle, D cycles after (h_cnt,v_cnt)=(0,0).
- First active pixel after reset release reaches rgb at cycle D, with frame_start=1.
- Defaults: line period 800 clocks, frame period 800*525 = 420000 clocks.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds port pattern_en, sampled only at v_cnt wrap, so a change takes effect at the next frame and never mid-frame.
  - When the sampled value is 1, rd_data is ignored. Active video shows 8 vertical bars, each H_ACTIVE/8 pixels wide (integer; any remainder joins bar 7).
  - Bar index k = {R,G,B} bits; each channel is all ones or zero. Bar 0 is black, bar 7 is white.
  - Bar timing goes through the same D-cycle alignment. rd_addr keeps counting normally.
- Not defined: port and pattern logic are absent, and rgb always comes from rd_data.

## Test plan
All scenarios use default parameters.
- Reset release -> hs first goes low at cycle 656+D, stays low 96 cycles, and repeats every 800 cycles. vs is low for lines 490-491 only. frame_start pulses once per 420000 cycles.
- Address sweep -> rd_addr is 0 at (0,0), 1 at (4,0), 159 at (639,0), 0 again at (0,3), 160 at (0,4), and 19199 at (639,479).
- Mono data with rd_data held at 1 -> rgb=3'b111 exactly while bright=1. rgb=0 in blanking, including the last D cycles of each line.
- MEM_LATENCY=3 build -> rgb, hs, vs and frame_start all shift by 4 cycles versus raw timing, and remain mutually aligned.
- Assert reset_n low at (300,200) for 5 cycles -> outputs go to reset values immediately. After release the next frame_start occurs at cycle D.
- VGA_TEST_PATTERN_EN build, pattern_en raised mid-frame -> no change until the next frame. Then rgb is 3'b000 for pixels 0-79, 3'b001 for 80-159, and so on up to 3'b111 for 560-639.

Source files
------------

// File: rtl/vga_scan_engine.sv
// Parametrised VGA scan engine: sync/blank timing, upscaled framebuffer addressing,
// and latency-aligned RGB output. Optional bar test pattern via VGA_TEST_PATTERN_EN.
module vga_scan_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_WIDTH  = 15,
  parameter int PIX_WIDTH   = 1,
  parameter int CH_BITS     = 1,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk_25,
  input  logic                    reset_n,
  input  logic [PIX_WIDTH-1:0]    rd_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                    pattern_en,
`endif
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [3*CH_BITS-1:0]    rgb,
  output logic                    hs,
  output logic                    vs,
  output logic                    bright,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int D       = MEM_LATENCY + 1;
  localparam int RGB_W   = 3 * CH_BITS;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_MASK     = HW'((1 << SCALE_SHIFT) - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MASK     = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] SRC_W = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);

  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  h_wrap, v_wrap;
  logic                  hs_raw, vs_raw, bright_raw, fs_raw;
  logic [D-1:0]          hs_pipe_q, vs_pipe_q, br_pipe_q, fs_pipe_q;
  logic [RGB_W-1:0]      rgb_q, rgb_d, data_rgb;

  // rd_addr tracks h_q so both describe the same pixel; the reload uses the
  // next line_base so the new line starts from the updated base.
  always_comb begin
    h_wrap      = (h_q == H_LAST);
    v_wrap      = (v_q == V_LAST);
    h_d         = h_wrap ? '0 : h_q + HW'(1);
    v_d         = v_q;
    line_base_d = line_base_q;
    rd_addr_d   = rd_addr_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + VW'(1);
      if (v_wrap)
        line_base_d = '0;
      else if ((v_q & V_MASK) == V_MASK)
        line_base_d = line_base_q + SRC_W;
      rd_addr_d = line_base_d;
    end else if (h_q < H_ACT_LAST && (h_q & H_MASK) == H_MASK) begin
      rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    hs_raw     = (h_q >= HS_BEG && h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_raw     = (v_q >= VS_BEG && v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
    bright_raw = (h_q < H_ACT) && (v_q < V_ACT);
    fs_raw     = (h_q == '0) && (v_q == '0);
  end

  generate
    if (PIX_WIDTH == 1) begin : g_mono
      always_comb data_rgb = {RGB_W{rd_data[0]}};
    end else begin : g_color
      always_comb data_rgb = rd_data[RGB_W-1:0];
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic             pat_q, pat_d;
  logic [2:0]       bar_raw;
  logic [3:0]       pat_pipe_q [D];
  logic [RGB_W-1:0] bar_rgb;

  // Pattern request only takes effect on a frame boundary.
  always_comb begin
    pat_d   = (h_wrap && v_wrap) ? pattern_en : pat_q;
    bar_raw = 3'd0;
    for (int unsigned i = 1; i < 8; i++)
      if (h_q >= HW'(i * BAR_W)) bar_raw = 3'(i);
  end

  always_comb begin
    bar_rgb = {{CH_BITS{pat_pipe_q[D-2][2]}},
               {CH_BITS{pat_pipe_q[D-2][1]}},
               {CH_BITS{pat_pipe_q[D-2][0]}}};
    rgb_d   = '0;
    if (br_pipe_q[D-2])
      rgb_d = pat_pipe_q[D-2][3] ? bar_rgb : data_rgb;
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= 1'b0;
      for (int unsigned i = 0; i < D; i++) pat_pipe_q[i] <= '0;
    end else begin
      pat_q         <= pat_d;
      pat_pipe_q[0] <= {pat_q, bar_raw};
      for (int unsigned i = 1; i < D; i++) pat_pipe_q[i] <= pat_pipe_q[i-1];
    end
  end
`else
  always_comb begin
    rgb_d = '0;
    if (br_pipe_q[D-2]) rgb_d = data_rgb;
  end
`endif

  // Stage D-2 of the delay line lines up with the returning read data,
  // so gating there keeps rgb and bright in step at the outputs.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      h_q         <= '0;
      v_q         <= '0;
      line_base_q <= '0;
      rd_addr_q   <= '0;
      hs_pipe_q   <= {D{~SYNC_POL}};
      vs_pipe_q   <= {D{~SYNC_POL}};
      br_pipe_q   <= '0;
      fs_pipe_q   <= '0;
      rgb_q       <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      line_base_q <= line_base_d;
      rd_addr_q   <= rd_addr_d;
      hs_pipe_q   <= {hs_pipe_q[D-2:0], hs_raw};
      vs_pipe_q   <= {vs_pipe_q[D-2:0], vs_raw};
      br_pipe_q   <= {br_pipe_q[D-2:0], bright_raw};
      fs_pipe_q   <= {fs_pipe_q[D-2:0], fs_raw};
      rgb_q       <= rgb_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign rgb         = rgb_q;
  assign hs          = hs_pipe_q[D-1];
  assign vs          = vs_pipe_q[D-1];
  assign bright      = br_pipe_q[D-1];
  assign frame_start = fs_pipe_q[D-1];

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: two reduced-timing instances (mono/latency 1 and
// colour/latency 3) checked every cycle against an arithmetic scan model.
module tb_vga_scan_engine;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VSY = 2, VBP = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [14:0] addr0;
  logic [2:0]  rgb0;
  logic        hs0, vs0, br0, fs0;
  logic        rd0;
  logic [9:0]  addr1;
  logic [5:0]  rgb1;
  logic        hs1, vs1, br1, fs1;
  logic [5:0]  rd1;
  logic [5:0]  p1 [3];
  logic [5:0]  mem [1024];
`ifdef VGA_TEST_PATTERN_EN
  logic        pattern_en = 1'b0;
`endif

  int ncmp = 0;
  int nfail = 0;
  int cur_n = -1;
  bit pat_frame [8];

  vga_scan_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b0), .SCALE_SHIFT(2), .ADDR_WIDTH(15),
    .PIX_WIDTH(1), .CH_BITS(1), .MEM_LATENCY(1)
  ) dut0 (
    .clk_25(clk), .reset_n(reset_n), .rd_data(rd0),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .rd_addr(addr0), .rgb(rgb0), .hs(hs0), .vs(vs0),
    .bright(br0), .frame_start(fs0)
  );

  vga_scan_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b1), .SCALE_SHIFT(1), .ADDR_WIDTH(10),
    .PIX_WIDTH(6), .CH_BITS(2), .MEM_LATENCY(3)
  ) dut1 (
    .clk_25(clk), .reset_n(reset_n), .rd_data(rd1),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .rd_addr(addr1), .rgb(rgb1), .hs(hs1), .vs(vs1),
    .bright(br1), .frame_start(fs1)
  );

  // Framebuffer models: latency 1 for dut0, latency 3 for dut1.
  always @(posedge clk) begin
    rd0   <= mem[addr0[9:0]][0];
    p1[0] <= mem[addr1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rd1 = p1[2];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, cur_n, obs, exp);
    end
  endtask

  // n = clock edges since reset release; n < 0 means reset is asserted.
  task automatic check(input int n);
    for (int k = 0; k < 2; k++) begin
      int lat, sh, aw, chb, d, p, h, v, hn, vn, kb, idx, e_rgb;
      bit pol, mono, e_hs, e_vs, e_br, e_fs;
      logic [31:0] o_addr, o_rgb;
      logic o_hs, o_vs, o_br, o_fs;
      logic [5:0] word;
      lat  = (k == 0) ? 1 : 3;
      sh   = (k == 0) ? 2 : 1;
      aw   = (k == 0) ? 15 : 10;
      chb  = (k == 0) ? 1 : 2;
      pol  = (k == 1);
      mono = (k == 0);
      if (k == 0) begin
        o_addr = 32'(addr0); o_rgb = 32'(rgb0);
        o_hs = hs0; o_vs = vs0; o_br = br0; o_fs = fs0;
      end else begin
        o_addr = 32'(addr1); o_rgb = 32'(rgb1);
        o_hs = hs1; o_vs = vs1; o_br = br1; o_fs = fs1;
      end
      d = lat + 1;
      p = n - d;
      e_hs = ~pol; e_vs = ~pol; e_br = 1'b0; e_fs = 1'b0; e_rgb = 0;
      if (n >= 0 && p >= 0) begin
        h = p % HT;
        v = (p / HT) % VT;
        e_hs = (h >= HA + HFP && h < HA + HFP + HSY) ? pol : ~pol;
        e_vs = (v >= VA + VFP && v < VA + VFP + VSY) ? pol : ~pol;
        e_br = (h < HA) && (v < VA);
        e_fs = (h == 0) && (v == 0);
        if (e_br) begin
          if (pat_frame[p / FT]) begin
            kb = h / (HA / 8);
            if (kb > 7) kb = 7;
            for (int c = 0; c < 3; c++)
              e_rgb = (e_rgb << chb) | ((((kb >> (2 - c)) & 1) != 0) ? ((1 << chb) - 1) : 0);
          end else begin
            idx  = ((v >> sh) * (HA >> sh) + (h >> sh)) % (1 << aw);
            word = mem[idx % 1024];
            e_rgb = mono ? (word[0] ? 7 : 0) : int'(word);
          end
        end
      end
      if (n < 0) begin
        cmp($sformatf("dut%0d.addr_rst", k), o_addr, 32'd0);
      end else begin
        hn = n % HT;
        vn = (n / HT) % VT;
        if (hn < HA && vn < VA)
          cmp($sformatf("dut%0d.addr", k), o_addr,
              32'(((vn >> sh) * (HA >> sh) + (hn >> sh)) % (1 << aw)));
      end
      cmp($sformatf("dut%0d.hs", k), 32'(o_hs), 32'(e_hs));
      cmp($sformatf("dut%0d.vs", k), 32'(o_vs), 32'(e_vs));
      cmp($sformatf("dut%0d.bright", k), 32'(o_br), 32'(e_br));
      cmp($sformatf("dut%0d.frame_start", k), 32'(o_fs), 32'(e_fs));
      cmp($sformatf("dut%0d.rgb", k), o_rgb, 32'(e_rgb));
    end
  endtask

  task automatic run_to(input int n_end);
    while (cur_n < n_end) begin
      @(posedge clk);
      #1;
      cur_n++;
      check(cur_n);
`ifdef VGA_TEST_PATTERN_EN
      if (cur_n == FT + FT / 3) pattern_en = 1'b1;
      if (cur_n % FT == FT - 1 && cur_n / FT + 1 < 8) pat_frame[cur_n / FT + 1] = pattern_en;
`endif
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cur_n = 0;
    #1;
    check(0);
  endtask

  initial begin
    int n_rst;
    for (int i = 0; i < 1024; i++) mem[i] = 6'($urandom);
    for (int i = 0; i < 8; i++) pat_frame[i] = 1'b0;

    #2 reset_n = 1'b0;
    #1 check(-1);
    repeat (3) @(posedge clk);
    #1 check(-1);

    release_reset();
    n_rst = 2 * FT + 10 * HT + int'($urandom_range(0, 20 * HT));
    run_to(n_rst);

    // Mid-frame reset: outputs must drop to reset values before any clock edge.
    @(negedge clk);
    reset_n = 1'b0;
    cur_n = -1;
    #1 check(-1);
    repeat (5) begin
      @(posedge clk);
      #1 check(-1);
    end
    for (int i = 0; i < 8; i++) pat_frame[i] = 1'b0;

    release_reset();
    run_to(FT + 12 * HT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
